// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg
// Shared types and helpers for the ALU execute-stage sequencer.
// - exec_state_t : sequencer states (idle, execute, writeback)
// - alu_instr_t  : instruction fields latched at issue
// - does_write() : whether an instruction produces a register-file write
// ISA codes are taken from isa.sv and re-exported as typed localparams so
// the sequencer and its users need no macro references.
package alu_exec_pkg;

`include "isa.sv"

    localparam int unsigned AluXlen    = 32;
    localparam int unsigned AluRegIdxW = 5;

    localparam logic [2:0] AluSelNop   = `ALU_SELECT_NOP;
    localparam logic [2:0] AluSelArith = `ALU_SELECT_ARITHMETIC;
    localparam logic [2:0] AluSelLoad  = `ALU_SELECT_LOAD;

    localparam logic [7:0] AluOpNop   = `ALU_OPERATIONS_NOP;
    localparam logic [7:0] AluOpAdd   = `ALU_OPERATIONS_ADD;
    localparam logic [7:0] AluOpSub   = `ALU_OPERATIONS_SUB;
    localparam logic [7:0] AluOpSll   = `ALU_OPERATIONS_SLL;
    localparam logic [7:0] AluOpSlt   = `ALU_OPERATIONS_SLT;
    localparam logic [7:0] AluOpSltu  = `ALU_OPERATIONS_SLTU;
    localparam logic [7:0] AluOpXor   = `ALU_OPERATIONS_XOR;
    localparam logic [7:0] AluOpSrl   = `ALU_OPERATIONS_SRL;
    localparam logic [7:0] AluOpSra   = `ALU_OPERATIONS_SRA;
    localparam logic [7:0] AluOpOr    = `ALU_OPERATIONS_OR;
    localparam logic [7:0] AluOpAnd   = `ALU_OPERATIONS_AND;
    localparam logic [7:0] AluOpAddi  = `ALU_OPERATIONS_ADDI;
    localparam logic [7:0] AluOpSlti  = `ALU_OPERATIONS_SLTI;
    localparam logic [7:0] AluOpSltiu = `ALU_OPERATIONS_SLTIU;
    localparam logic [7:0] AluOpXori  = `ALU_OPERATIONS_XORI;
    localparam logic [7:0] AluOpOri   = `ALU_OPERATIONS_ORI;
    localparam logic [7:0] AluOpAndi  = `ALU_OPERATIONS_ANDI;
    localparam logic [7:0] AluOpSlli  = `ALU_OPERATIONS_SLLI;
    localparam logic [7:0] AluOpSrli  = `ALU_OPERATIONS_SRLI;
    localparam logic [7:0] AluOpSrai  = `ALU_OPERATIONS_SRAI;
    localparam logic [7:0] AluOpLui   = `ALU_OPERATIONS_LUI;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWb
    } exec_state_t;

    typedef struct packed {
        logic [2:0]            select;
        logic [7:0]            operation;
        logic [AluRegIdxW-1:0] rd;
        logic [AluXlen-1:0]    s1;
        logic [AluXlen-1:0]    s2;
        logic [AluXlen-1:0]    imm;
    } alu_instr_t;

    // Register-register and register-immediate codes the ALU implements.
    function automatic logic is_write_op(input logic [7:0] op);
        return op inside {AluOpAdd, AluOpSub, AluOpSll, AluOpSlt, AluOpSltu,
                          AluOpXor, AluOpSrl, AluOpSra, AluOpOr, AluOpAnd,
                          AluOpAddi, AluOpSlti, AluOpSltiu, AluOpXori, AluOpOri,
                          AluOpAndi, AluOpSlli, AluOpSrli, AluOpSrai, AluOpLui};
    endfunction

    // Only arithmetic instructions with a real destination reach writeback.
    function automatic logic does_write(input logic [2:0]            sel,
                                        input logic [7:0]            op,
                                        input logic [AluRegIdxW-1:0] rd);
        return (sel == AluSelArith) && (rd != '0) && is_write_op(op);
    endfunction

endpackage

// File: rtl/alu_exec_bypass.sv
// alu_exec_bypass
// Per-operand forwarding mux: substitutes the value sitting on the
// writeback port for a register-file read of the same register.
// Ports:
// - fwd_en  : forwarding allowed this cycle (producer in writeback)
// - src_idx : source register index of the issuing instruction
// - src_val : value read from the register file
// - wb_rd   : destination index currently on the writeback port
// - wb_data : value currently on the writeback port
// - op_val  : operand to latch
module alu_exec_bypass
    import alu_exec_pkg::*;
#(
    parameter int unsigned XLEN      = AluXlen,
    parameter int unsigned REG_IDX_W = AluRegIdxW
) (
    input  logic                 fwd_en,
    input  logic [REG_IDX_W-1:0] src_idx,
    input  logic [XLEN-1:0]      src_val,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic [XLEN-1:0]      op_val
);

    // x0 is never forwarded; it always reads as zero from the register file.
    always_comb begin
        op_val = src_val;
        if (fwd_en && (wb_rd != '0) && (src_idx == wb_rd)) begin
            op_val = wb_data;
        end
    end

endmodule

// File: rtl/isa.sv
// isa.sv
// RV32I ALU select and operation codes shared by decode, the ALU and the
// execute-stage sequencer. Text include only; it declares no module.
// Select codes are 3 bits wide and operation codes are 8 bits wide.
`ifndef ISA_SV
`define ISA_SV

`define ALU_SELECT_NOP         3'd0
`define ALU_SELECT_ARITHMETIC  3'd1
`define ALU_SELECT_LOAD        3'd2
`define ALU_SELECT_STORE       3'd3
`define ALU_SELECT_BRANCH      3'd4

`define ALU_OPERATIONS_NOP     8'h00
`define ALU_OPERATIONS_ADD     8'h01
`define ALU_OPERATIONS_SUB     8'h02
`define ALU_OPERATIONS_SLL     8'h03
`define ALU_OPERATIONS_SLT     8'h04
`define ALU_OPERATIONS_SLTU    8'h05
`define ALU_OPERATIONS_XOR     8'h06
`define ALU_OPERATIONS_SRL     8'h07
`define ALU_OPERATIONS_SRA     8'h08
`define ALU_OPERATIONS_OR      8'h09
`define ALU_OPERATIONS_AND     8'h0A
`define ALU_OPERATIONS_ADDI    8'h11
`define ALU_OPERATIONS_SLTI    8'h12
`define ALU_OPERATIONS_SLTIU   8'h13
`define ALU_OPERATIONS_XORI    8'h14
`define ALU_OPERATIONS_ORI     8'h15
`define ALU_OPERATIONS_ANDI    8'h16
`define ALU_OPERATIONS_SLLI    8'h17
`define ALU_OPERATIONS_SRLI    8'h18
`define ALU_OPERATIONS_SRAI    8'h19
`define ALU_OPERATIONS_LUI     8'h1A

`endif

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
// Execute-stage sequencer for the RV32I combinational ALU. Takes one decoded
// ALU instruction over a valid/ready issue port, holds its operands on the
// alu_* outputs for one cycle, captures the ALU result and offers it to the
// register file over a valid/ready writeback port.
// Ports:
// - clk, rst            : clock, synchronous active-high reset
// - flush               : drop the in-flight instruction (highest priority)
// - issue_*             : issue handshake and decoded instruction fields
// - alu_*               : drive/receive the external ALU
// - wb_valid/ready/rd/data : writeback handshake to the register file
// - pending_valid/rd    : destination of the in-flight writing instruction
// Configuration: define ALU_EXEC_BYPASS_EN to forward the writeback value to
// an instruction issued in the same cycle the writeback completes.
// XLEN and REG_IDX_W must match AluXlen and AluRegIdxW in alu_exec_pkg.
module alu_exec_ctrl
    import alu_exec_pkg::*;
#(
    parameter int unsigned XLEN      = AluXlen,
    parameter int unsigned REG_IDX_W = AluRegIdxW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,

    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [2:0]           issue_alu_select,
    input  logic [7:0]           issue_alu_operation,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] issue_rs1_idx,
    input  logic [REG_IDX_W-1:0] issue_rs2_idx,
    input  logic [XLEN-1:0]      issue_rs1_val,
    input  logic [XLEN-1:0]      issue_rs2_val,
    input  logic [XLEN-1:0]      issue_imm,

    output logic [2:0]           alu_select,
    output logic [7:0]           alu_operation,
    output logic [XLEN-1:0]      alu_reg_s1,
    output logic [XLEN-1:0]      alu_reg_s2,
    output logic [XLEN-1:0]      alu_imm_value,
    input  logic [XLEN-1:0]      alu_reg_destination,

    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data,

    output logic                 pending_valid,
    output logic [REG_IDX_W-1:0] pending_rd
);

    exec_state_t     state;
    alu_instr_t      instr_q;
    alu_instr_t      issue_instr;
    logic            issue_fire;
    logic            issue_writes;
    logic [XLEN-1:0] op1_val;
    logic [XLEN-1:0] op2_val;

    // Ready only when the stage is empty or the writeback drains this cycle.
    always_comb begin
        issue_ready = 1'b0;
        if (!flush) begin
            case (state)
                StIdle:  issue_ready = 1'b1;
                StWb:    issue_ready = wb_ready;
                default: issue_ready = 1'b0;
            endcase
        end
    end

    assign issue_fire = issue_valid && issue_ready;

`ifdef ALU_EXEC_BYPASS_EN
    // A fire in StWb implies wb_ready=1, so the producer retires this cycle.
    logic fwd_en;
    assign fwd_en = (state == StWb);

    alu_exec_bypass #(
        .XLEN      (XLEN),
        .REG_IDX_W (REG_IDX_W)
    ) u_bypass_rs1 (
        .fwd_en  (fwd_en),
        .src_idx (issue_rs1_idx),
        .src_val (issue_rs1_val),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .op_val  (op1_val)
    );

    alu_exec_bypass #(
        .XLEN      (XLEN),
        .REG_IDX_W (REG_IDX_W)
    ) u_bypass_rs2 (
        .fwd_en  (fwd_en),
        .src_idx (issue_rs2_idx),
        .src_val (issue_rs2_val),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .op_val  (op2_val)
    );
`else
    assign op1_val = issue_rs1_val;
    assign op2_val = issue_rs2_val;

    // Source indices only matter for forwarding.
    logic unused_src_idx;
    assign unused_src_idx = ^{issue_rs1_idx, issue_rs2_idx};
`endif

    always_comb begin
        issue_instr           = '0;
        issue_instr.select    = issue_alu_select;
        issue_instr.operation = issue_alu_operation;
        issue_instr.rd        = issue_rd;
        issue_instr.s1        = op1_val;
        issue_instr.s2        = op2_val;
        issue_instr.imm       = issue_imm;
    end

    assign issue_writes = does_write(issue_alu_select, issue_alu_operation, issue_rd);

    assign alu_reg_s1    = instr_q.s1;
    assign alu_reg_s2    = instr_q.s2;
    assign alu_imm_value = instr_q.imm;
    assign pending_rd    = instr_q.rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            instr_q       <= '0;
            alu_select    <= AluSelNop;
            alu_operation <= AluOpNop;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            pending_valid <= 1'b0;
        end else if (flush) begin
            // wb_rd/wb_data keep their values; wb_valid=0 marks them stale.
            state         <= StIdle;
            alu_select    <= AluSelNop;
            alu_operation <= AluOpNop;
            wb_valid      <= 1'b0;
            pending_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (issue_fire) begin
                        state         <= StExec;
                        instr_q       <= issue_instr;
                        alu_select    <= issue_alu_select;
                        alu_operation <= issue_alu_operation;
                        pending_valid <= issue_writes;
                    end
                end
                StExec: begin
                    alu_select    <= AluSelNop;
                    alu_operation <= AluOpNop;
                    if (does_write(instr_q.select, instr_q.operation, instr_q.rd)) begin
                        state    <= StWb;
                        wb_valid <= 1'b1;
                        wb_rd    <= instr_q.rd;
                        wb_data  <= alu_reg_destination;
                    end else begin
                        // rd==x0, non-arithmetic or undefined: result discarded.
                        state         <= StIdle;
                        pending_valid <= 1'b0;
                    end
                end
                StWb: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        if (issue_fire) begin
                            state         <= StExec;
                            instr_q       <= issue_instr;
                            alu_select    <= issue_alu_select;
                            alu_operation <= issue_alu_operation;
                            pending_valid <= issue_writes;
                        end else begin
                            state         <= StIdle;
                            pending_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
